// File: rtl/pc_stack_if.sv
// Request/status bundle between a sequencer and the pc_stack program counter.
// The sequencer drives the request side (master); pc_stack answers (slave).
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    depth_cnt;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output clr, in, load, inc, call, ret,
        input  out, depth_cnt, empty, full, ovf, unf
    );

    modport slave (
        input  clr, in, load, inc, call, ret,
        output out, depth_cnt, empty, full, ovf, unf
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for call/return.
// One action per edge, priority clr > ret > call > load > inc > hold.
module pc_stack #(
    parameter int          WIDTH        = 16,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    pc_stack_if.slave   bus
);
    localparam int               CW = $clog2(DEPTH + 1);
    localparam int               AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] RV = RESET_VECTOR[WIDTH-1:0];

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_POP,
        ACT_UNF,
        ACT_PUSH,
        ACT_OVF,
        ACT_LOAD,
        ACT_INC
    } act_e;

    act_e             act;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] pc_plus1;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));
    assign push_idx = AW'(cnt_q);
    assign top_idx  = AW'(cnt_q - CW'(1));
    // Shared by inc and the return address; wraps all-ones to zero.
    assign pc_plus1 = out_q + WIDTH'(1);

    always_comb begin
        act = ACT_HOLD;
        if (bus.clr) begin
            act = ACT_CLR;
        end else if (bus.ret) begin
            act = is_empty ? ACT_UNF : ACT_POP;
        end else if (bus.call) begin
            act = is_full ? ACT_OVF : ACT_PUSH;
        end else if (bus.load) begin
            act = ACT_LOAD;
        end else if (bus.inc) begin
            act = ACT_INC;
        end
    end

    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        case (act)
            ACT_CLR: begin
                out_d = RV;
                cnt_d = '0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            ACT_POP: begin
                out_d = stack_q[top_idx];
                cnt_d = cnt_q - CW'(1);
            end
            ACT_UNF:  unf_d = 1'b1;
            ACT_PUSH: begin
                out_d = bus.in;
                cnt_d = cnt_q + CW'(1);
            end
            ACT_OVF:  ovf_d = 1'b1;
            ACT_LOAD: out_d = bus.in;
            ACT_INC:  out_d = pc_plus1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RV;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is deliberately unreset: entries above depth_cnt are never read.
    always_ff @(posedge clk) begin
        if (act == ACT_PUSH) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

    assign bus.out       = out_q;
    assign bus.depth_cnt = cnt_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q <= CW'(DEPTH));
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table plus hand-written sequences,
// expected results queued when stimulus is driven and compared after the edge.
module tb_pc_stack;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_CLR  = 5'b10000;
    localparam logic [4:0] C_RET  = 5'b01000;
    localparam logic [4:0] C_CALL = 5'b00100;
    localparam logic [4:0] C_LOAD = 5'b00010;
    localparam logic [4:0] C_INC  = 5'b00001;

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [CW-1:0] cnt;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } res_t;

    typedef struct packed {
        logic [4:0]   ctl;
        logic [W-1:0] din;
        res_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pc_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[27];

    function automatic res_t r(input logic [W-1:0] pc, input int cnt,
                               input logic ovf, input logic unf);
        res_t x;
        x.pc    = pc;
        x.cnt   = CW'(cnt);
        x.empty = (cnt == 0);
        x.full  = (cnt == D);
        x.ovf   = ovf;
        x.unf   = unf;
        return x;
    endfunction

    function automatic vec_t mk(input logic [4:0] ctl, input logic [W-1:0] din,
                                input res_t e);
        vec_t v;
        v.ctl = ctl;
        v.din = din;
        v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic [4:0] ctl, input logic [W-1:0] din);
        {bus.clr, bus.ret, bus.call, bus.load, bus.inc} = ctl;
        bus.in = din;
    endtask

    task automatic check(input string name);
        res_t a, e;
        a = {bus.out, bus.depth_cnt, bus.empty, bus.full, bus.ovf, bus.unf};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected result queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL %s: got pc=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, required pc=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
                          name, a.pc, a.cnt, a.empty, a.full, a.ovf, a.unf,
                          e.pc, e.cnt, e.empty, e.full, e.ovf, e.unf);
        end
    endtask

    task automatic step(input string name, input logic [4:0] ctl,
                        input logic [W-1:0] din, input res_t e);
        @(negedge clk);
        drive(ctl, din);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        // Straight-line behaviour, hand-computed expectations.
        vecs[0]  = mk(C_INC,  16'h0000, r(16'h0001, 0, 0, 0));
        vecs[1]  = mk(C_INC,  16'h0000, r(16'h0002, 0, 0, 0));
        vecs[2]  = mk(C_INC,  16'h0000, r(16'h0003, 0, 0, 0));
        vecs[3]  = mk(C_LOAD, 16'h0100, r(16'h0100, 0, 0, 0));
        vecs[4]  = mk(C_LOAD, 16'h0010, r(16'h0010, 0, 0, 0));
        vecs[5]  = mk(C_CALL, 16'h0200, r(16'h0200, 1, 0, 0));
        vecs[6]  = mk(C_INC,  16'h0000, r(16'h0201, 1, 0, 0));
        vecs[7]  = mk(C_RET,  16'h0000, r(16'h0011, 0, 0, 0));
        vecs[8]  = mk(C_LOAD, 16'hFFFF, r(16'hFFFF, 0, 0, 0));
        vecs[9]  = mk(C_INC,  16'h0000, r(16'h0000, 0, 0, 0));
        vecs[10] = mk(C_LOAD, 16'hFFFF, r(16'hFFFF, 0, 0, 0));
        vecs[11] = mk(C_CALL, 16'h0040, r(16'h0040, 1, 0, 0));
        vecs[12] = mk(C_RET,  16'h0000, r(16'h0000, 0, 0, 0));
        vecs[13] = mk(C_RET,  16'h0000, r(16'h0000, 0, 0, 1));
        vecs[14] = mk(C_INC,  16'h0000, r(16'h0001, 0, 0, 1));
        vecs[15] = mk(C_CLR,  16'h0000, r(16'h0000, 0, 0, 0));
        vecs[16] = mk(C_LOAD, 16'h0500, r(16'h0500, 0, 0, 0));
        vecs[17] = mk(C_CALL, 16'h0600, r(16'h0600, 1, 0, 0));
        vecs[18] = mk(C_CALL | C_RET | C_LOAD, 16'h0777, r(16'h0501, 0, 0, 0));
        vecs[19] = mk(C_LOAD, 16'h0123, r(16'h0123, 0, 0, 0));
        vecs[20] = mk(C_CALL, 16'h0300, r(16'h0300, 1, 0, 0));
        vecs[21] = mk(C_CLR | C_CALL, 16'h0400, r(16'h0000, 0, 0, 0));
        vecs[22] = mk(C_NONE, 16'h0999, r(16'h0000, 0, 0, 0));
        vecs[23] = mk(C_LOAD | C_INC, 16'h0AAA, r(16'h0AAA, 0, 0, 0));
        vecs[24] = mk(C_NONE, 16'h0BBB, r(16'h0AAA, 0, 0, 0));
        vecs[25] = mk(C_RET | C_LOAD, 16'h0555, r(16'h0AAA, 0, 0, 1));
        vecs[26] = mk(C_CLR,  16'h0000, r(16'h0000, 0, 0, 0));

        // Asynchronous reset takes effect before any clock edge.
        reset_n = 1'b0;
        drive(C_NONE, '0);
        #3;
        exp_q.push_back(r(16'h0000, 0, 0, 0));
        check("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].din, vecs[i].exp);
        end

        // Fill the stack, overflow once, drain it, underflow once.
        step("nest_load", C_LOAD, 16'h1000, r(16'h1000, 0, 0, 0));
        for (int i = 0; i < D; i++) begin
            step($sformatf("nest_call%0d", i), C_CALL, W'(16'h2000 + i * 16'h10),
                 r(W'(16'h2000 + i * 16'h10), i + 1, 0, 0));
        end
        step("call_ovf", C_CALL, 16'h3000, r(16'h2070, D, 1, 0));
        for (int k = 0; k < D; k++) begin
            step($sformatf("nest_ret%0d", k), C_RET, 16'h0000,
                 r((k < D - 1) ? W'(16'h2000 + (D - 2 - k) * 16'h10 + 1) : 16'h1001,
                   D - 1 - k, 1, 0));
        end
        step("ret_unf", C_RET, 16'h0000, r(16'h1001, 0, 1, 1));
        step("ret_unf_sticky", C_RET, 16'h0000, r(16'h1001, 0, 1, 1));
        step("clr_flags", C_CLR, 16'h0000, r(16'h0000, 0, 0, 0));

        // Reset pulse between edges discards pending return addresses.
        step("ar_load",  C_LOAD, 16'h0700, r(16'h0700, 0, 0, 0));
        step("ar_call1", C_CALL, 16'h0710, r(16'h0710, 1, 0, 0));
        step("ar_call2", C_CALL, 16'h0720, r(16'h0720, 2, 0, 0));
        step("ar_call3", C_CALL, 16'h0730, r(16'h0730, 3, 0, 0));
        @(negedge clk);
        drive(C_NONE, '0);
        #1 reset_n = 1'b0;
        #1;
        exp_q.push_back(r(16'h0000, 0, 0, 0));
        check("async_reset");
        #1 reset_n = 1'b1;
        step("post_rst_ret",  C_RET,  16'h0000, r(16'h0000, 0, 0, 1));
        step("post_rst_call", C_CALL, 16'h0800, r(16'h0800, 1, 0, 1));
        step("post_rst_pop",  C_RET,  16'h0000, r(16'h0001, 0, 0, 1));

        @(negedge clk);
        drive(C_NONE, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the program counter and return-address width in bits (range 4..32).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of return-address stack entries (range 2..64).
REQ-003 Parameter RESET_VECTOR, default 0, SHALL set the counter value after reset or clear, truncated to WIDTH bits.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 clr  input  1  SHALL be a synchronous clear.
REQ-007 in  input  WIDTH  SHALL be the target address for load and call.
REQ-008 load  input  1  SHALL be the jump request: counter <= in.
REQ-009 inc  input  1  SHALL be the increment request.
REQ-010 call  input  1  SHALL be the subroutine call request: push the return address, then jump to in.
REQ-011 ret  input  1  SHALL be the subroutine return request: pop the stack into the counter.
REQ-012 out  output  WIDTH  SHALL present the current counter value as a register output.
REQ-013 depth_cnt  output  $clog2(DEPTH+1)  SHALL give the number of valid stack entries.
REQ-014 empty / full  output  1 each  SHALL be high when depth_cnt==0 / depth_cnt==DEPTH.
REQ-015 ovf / unf  output  1 each  SHALL be sticky flags: call rejected because full / ret rejected because empty.

Function
REQ-016 Per-edge priority SHALL be clr > ret > call > load > inc > hold; exactly one action per cycle.
REQ-017 clr SHALL set out=RESET_VECTOR, depth_cnt=0, ovf=0 and unf=0 on the next edge; stack contents become don't-care.
REQ-018 ret with depth_cnt>0 SHALL set out to the top entry and decrement depth_cnt; the result is visible the cycle after the edge.
REQ-019 ret with depth_cnt==0 SHALL leave out and depth_cnt unchanged and set unf=1.
REQ-020 call with depth_cnt<DEPTH SHALL push (out+1) mod 2^WIDTH, set out=in, and increment depth_cnt.
REQ-021 call with depth_cnt==DEPTH SHALL leave out, the stack and depth_cnt unchanged and set ovf=1; there is no silent overwrite.
REQ-022 load SHALL set out=in; the stack is unaffected.
REQ-023 inc SHALL set out=(out+1) mod 2^WIDTH, so all-ones wraps to 0; the stack is unaffected.
REQ-024 With no request active, all state SHALL hold.
REQ-025 call and ret asserted together SHALL perform ret only.
REQ-026 The stack SHALL be LIFO: entries are stored at index depth_cnt-1 and popped from the same index.
REQ-027 A return address computed when out is all ones SHALL be 0 (wrap-around).
REQ-028 empty, full and depth_cnt SHALL be derived from the registered count, with no combinational path from the request inputs.
REQ-029 ovf and unf SHALL stay set until clr or reset; further rejected requests keep them at 1.

Reset
REQ-030 reset_n low SHALL immediately, without a clock, force out=RESET_VECTOR, depth_cnt=0, empty=1, full=0, ovf=0, unf=0.
REQ-031 Stack storage SHALL NOT require reset; its contents are don't-care while depth_cnt==0.
REQ-032 Reset asserted mid-sequence (for example between a call and its ret) SHALL discard all pending return addresses.
REQ-033 Release of reset_n SHALL be synchronised by the surrounding system; the first edge after release SHALL process the requests normally.

Verification
REQ-034 Reset then inc x3 -> out=0,1,2,3; load in=0x0100 -> out=0x0100; depth_cnt=0 throughout.
REQ-035 out=0x0010, call in=0x0200 -> out=0x0200, depth_cnt=1; inc; ret -> out=0x0011, depth_cnt=0, empty=1.
REQ-036 Nested calls to DEPTH=8 -> full=1; a 9th call -> ovf=1, out unchanged; 8 rets return the addresses in reverse order; a 9th ret -> unf=1, out unchanged.
REQ-037 out=0xFFFF: inc -> 0x0000; at out=0xFFFF call in=0x0040, then ret -> out=0x0000.
REQ-038 call+ret+load together with depth_cnt=1 -> pop only; clr+call together -> out=RESET_VECTOR, depth_cnt=0, flags cleared.
REQ-039 reset_n pulsed low between clock edges with depth_cnt=3 -> out=RESET_VECTOR and depth_cnt=0 before the next edge; a following ret -> unf=1.
